soc2_uart_rx_core: RTL and testbench

//   UART receive core behind the soc2 peripheral UART. It takes the raw uart_rx pad line, synchronises it, and

---
 rtl/soc2_uart_rx_core_if.sv | 23 ++
 rtl/soc2_uart_rx_core.sv | 142 ++++++++++++++
 tb/tb_soc2_uart_rx_core.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/soc2_uart_rx_core_if.sv
// Receive-side byte handshake between the UART rx core and the register/bus interface.
// Latency: none (wires only).
// Backpressure: rx_ready from the consumer pops the one-entry holding register in the core.
// Signals: rx_data/rx_valid (byte + full flag), rx_ready (pop), frame_err/overrun (1-cycle error pulses).
interface soc2_uart_rx_core_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  // Core side: produces bytes and error pulses, consumes ready.
  modport master (
    output rx_data, rx_valid, frame_err, overrun,
    input  rx_ready
  );

  // Consumer side: reads bytes and error pulses, drives ready.
  modport slave (
    input  rx_data, rx_valid, frame_err, overrun,
    output rx_ready
  );
endinterface

// File: rtl/soc2_uart_rx_core.sv
// UART 8N1 receiver: pad synchroniser, start-edge detect, mid-bit sampling, one-entry holding register.
// Latency: pad fall to rx_valid = 2 + BAUD_DIV/2 + 9*BAUD_DIV + 1 cycles (+-1 for pad phase).
// Backpressure: none toward the line; a byte completing while the holder is full and not popped is dropped (overrun pulse).
// Ports: clk, resetn (sync, active low), uart_rx (async pad, idle high), rx_busy (FSM not idle),
//        rx_if.master: rx_data/rx_valid/rx_ready handshake plus frame_err/overrun pulses.
module soc2_uart_rx_core #(
  parameter int BAUD_DIV = 434,
  parameter int CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   uart_rx,
  output logic                   rx_busy,
  soc2_uart_rx_core_if.master    rx_if
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(BAUD_DIV - 1);

  // Synchroniser and edge-detect flops.
  logic rx_meta, rx_s, rx_p;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       shift, shift_nxt;

  // Holding register and error pulses.
  logic [7:0] data_q, data_nxt;
  logic       valid_q, valid_nxt;
  logic       ferr_q, ferr_nxt;
  logic       ovr_q, ovr_nxt;

  logic tick, start_edge, stop_done;

  assign tick       = (cnt == '0);
  assign start_edge = rx_p & ~rx_s;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    stop_done   = 1'b0;
    unique case (state)
      IDLE: begin
        // Only a genuine 1->0 transition starts a frame; a line stuck low does not.
        if (start_edge) begin
          cnt_nxt   = HALF_RELOAD;
          state_nxt = START;
        end
      end
      START: begin
        if (!tick) begin
          cnt_nxt = cnt - 1'b1;
        end else if (!rx_s) begin
          cnt_nxt     = BIT_RELOAD;
          bit_idx_nxt = 3'd0;
          state_nxt   = DATA;
        end else begin
          state_nxt = IDLE;  // glitch shorter than half a bit
        end
      end
      DATA: begin
        if (!tick) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          shift_nxt = {rx_s, shift[7:1]};  // LSB arrives first
          cnt_nxt   = BIT_RELOAD;
          if (bit_idx == 3'd7) state_nxt = STOP;
          else                 bit_idx_nxt = bit_idx + 3'd1;
        end
      end
      STOP: begin
        if (!tick) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          // Return to IDLE at mid stop bit so the next start edge is never missed.
          stop_done = 1'b1;
          cnt_nxt   = BIT_RELOAD;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    data_nxt  = data_q;
    valid_nxt = valid_q & ~rx_if.rx_ready;
    ferr_nxt  = 1'b0;
    ovr_nxt   = 1'b0;
    if (stop_done) begin
      if (!rx_s) begin
        ferr_nxt = 1'b1;
      end else if (!valid_q || rx_if.rx_ready) begin
        // Empty holder, or a pop in the same cycle frees the slot.
        data_nxt  = shift;
        valid_nxt = 1'b1;
      end else begin
        ovr_nxt = 1'b1;  // old byte kept, new one dropped
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_p    <= 1'b1;
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
      rx_p    <= rx_s;
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
      data_q  <= data_nxt;
      valid_q <= valid_nxt;
      ferr_q  <= ferr_nxt;
      ovr_q   <= ovr_nxt;
    end
  end

  assign rx_busy         = (state != IDLE);
  assign rx_if.rx_data   = data_q;
  assign rx_if.rx_valid  = valid_q;
  assign rx_if.frame_err = ferr_q;
  assign rx_if.overrun   = ovr_q;

endmodule

// File: tb/tb_soc2_uart_rx_core.sv
// Bench for soc2_uart_rx_core at BAUD_DIV=8: directed scenarios plus randomized frames against a
// holding-register model (empty/full, pop, overrun, framing error) kept at byte level.
module tb_soc2_uart_rx_core;
  localparam int B = 8;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic uart_rx = 1'b1;
  logic rx_busy;

  soc2_uart_rx_core_if rif ();

  soc2_uart_rx_core #(.BAUD_DIV(B), .CNT_W(16)) dut (
    .clk    (clk),
    .resetn (resetn),
    .uart_rx(uart_rx),
    .rx_busy(rx_busy),
    .rx_if  (rif)
  );

  always #5 clk = ~clk;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int fe_seen = 0;
  int ov_seen = 0;
  int both_seen = 0;

  always @(negedge clk) begin
    if (rif.frame_err) fe_seen++;
    if (rif.overrun) ov_seen++;
    if (rif.frame_err && rif.overrun) both_seen++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives start, 8 data bits LSB first, and a stop bit; line left at the stop value.
  task automatic drive_frame(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    tick_n(B);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick_n(B);
    end
    uart_rx = stop;
    tick_n(B);
  endtask

  task automatic pop();
    rif.rx_ready = 1'b1;
    tick_n(1);
    rif.rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    uart_rx = 1'b1;
    rif.rx_ready = 1'b0;
    tick_n(3);
    resetn = 1'b1;
    chk_cnt++; if (rif.rx_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", rif.rx_valid); else pass_cnt++;
    chk_cnt++; if (rif.rx_data !== 8'h00) $display("FAIL reset_data: got %h expected 00", rif.rx_data); else pass_cnt++;
    chk_cnt++; if (rx_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", rx_busy); else pass_cnt++;
    chk_cnt++; if (rif.frame_err !== 1'b0) $display("FAIL reset_ferr: got %b expected 0", rif.frame_err); else pass_cnt++;
    chk_cnt++; if (rif.overrun !== 1'b0) $display("FAIL reset_ovr: got %b expected 0", rif.overrun); else pass_cnt++;
    tick_n(4);
  endtask

  task automatic test_single();
    int n;
    int fe0, ov0;
    fe0 = fe_seen; ov0 = ov_seen;
    n = 0;
    fork
      drive_frame(8'hA5, 1'b1);
      begin
        #1;
        while (!rif.rx_valid && n < 200) begin
          @(posedge clk);
          #2;
          n++;
        end
      end
    join
    uart_rx = 1'b1;
    tick_n(2);
    chk_cnt++; if (n !== 2 + B / 2 + 9 * B + 1) $display("FAIL latency: got %0d expected %0d", n, 2 + B / 2 + 9 * B + 1); else pass_cnt++;
    chk_cnt++; if (rif.rx_valid !== 1'b1) $display("FAIL single_valid: got %b expected 1", rif.rx_valid); else pass_cnt++;
    chk_cnt++; if (rif.rx_data !== 8'hA5) $display("FAIL single_data: got %h expected a5", rif.rx_data); else pass_cnt++;
    chk_cnt++; if (fe_seen - fe0 !== 0 || ov_seen - ov0 !== 0) $display("FAIL single_pulses: got fe=%0d ov=%0d expected 0 0", fe_seen - fe0, ov_seen - ov0); else pass_cnt++;
    pop();
    chk_cnt++; if (rif.rx_valid !== 1'b0) $display("FAIL pop_valid: got %b expected 0", rif.rx_valid); else pass_cnt++;
    chk_cnt++; if (rif.rx_data !== 8'hA5) $display("FAIL pop_data_hold: got %h expected a5", rif.rx_data); else pass_cnt++;
    // ready while empty must be ignored
    pop();
    chk_cnt++; if (rif.rx_valid !== 1'b0) $display("FAIL ready_when_empty: got %b expected 0", rif.rx_valid); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int ov0;
    ov0 = ov_seen;
    drive_frame(8'h3C, 1'b1);
    drive_frame(8'h7E, 1'b1);
    uart_rx = 1'b1;
    tick_n(2);
    chk_cnt++; if (rif.rx_data !== 8'h3C) $display("FAIL b2b_data: got %h expected 3c", rif.rx_data); else pass_cnt++;
    chk_cnt++; if (rif.rx_valid !== 1'b1) $display("FAIL b2b_valid: got %b expected 1", rif.rx_valid); else pass_cnt++;
    chk_cnt++; if (ov_seen - ov0 !== 1) $display("FAIL b2b_overrun: got %0d expected 1", ov_seen - ov0); else pass_cnt++;
    pop();
  endtask

  task automatic test_b2b_pop_on_delivery();
    int ov0;
    ov0 = ov_seen;
    fork
      begin
        drive_frame(8'h3C, 1'b1);
        drive_frame(8'h7E, 1'b1);
      end
      begin
        // Second frame's stop sample is evaluated between edges 158 and 159.
        tick_n(2 * 10 * B - 2);
        rif.rx_ready = 1'b1;
        tick_n(1);
        rif.rx_ready = 1'b0;
      end
    join
    uart_rx = 1'b1;
    tick_n(2);
    chk_cnt++; if (rif.rx_data !== 8'h7E) $display("FAIL popdeliv_data: got %h expected 7e", rif.rx_data); else pass_cnt++;
    chk_cnt++; if (rif.rx_valid !== 1'b1) $display("FAIL popdeliv_valid: got %b expected 1", rif.rx_valid); else pass_cnt++;
    chk_cnt++; if (ov_seen - ov0 !== 0) $display("FAIL popdeliv_overrun: got %0d expected 0", ov_seen - ov0); else pass_cnt++;
    pop();
  endtask

  task automatic test_framing();
    int fe0;
    fe0 = fe_seen;
    drive_frame(8'h55, 1'b0);
    tick_n(2);
    chk_cnt++; if (fe_seen - fe0 !== 1) $display("FAIL ferr_pulse: got %0d expected 1", fe_seen - fe0); else pass_cnt++;
    chk_cnt++; if (rif.rx_valid !== 1'b0) $display("FAIL ferr_valid: got %b expected 0", rif.rx_valid); else pass_cnt++;
    tick_n(20 * B);
    chk_cnt++; if (rx_busy !== 1'b0) $display("FAIL low_line_busy: got %b expected 0", rx_busy); else pass_cnt++;
    uart_rx = 1'b1;
    tick_n(2 * B);
    drive_frame(8'h01, 1'b1);
    uart_rx = 1'b1;
    tick_n(2);
    chk_cnt++; if (rif.rx_valid !== 1'b1 || rif.rx_data !== 8'h01) $display("FAIL ferr_recover: got v=%b d=%h expected v=1 d=01", rif.rx_valid, rif.rx_data); else pass_cnt++;
    chk_cnt++; if (fe_seen - fe0 !== 1) $display("FAIL ferr_total: got %0d expected 1", fe_seen - fe0); else pass_cnt++;
    pop();
  endtask

  task automatic test_glitch();
    logic [7:0] d0;
    logic v0, saw_busy;
    int fe0, ov0;
    d0 = rif.rx_data; v0 = rif.rx_valid; fe0 = fe_seen; ov0 = ov_seen;
    saw_busy = 1'b0;
    uart_rx = 1'b0;
    tick_n(3);
    uart_rx = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick_n(1);
      if (rx_busy) saw_busy = 1'b1;
    end
    chk_cnt++; if (saw_busy !== 1'b1) $display("FAIL glitch_busy_seen: got %b expected 1", saw_busy); else pass_cnt++;
    chk_cnt++; if (rx_busy !== 1'b0) $display("FAIL glitch_busy_end: got %b expected 0", rx_busy); else pass_cnt++;
    chk_cnt++; if (rif.rx_valid !== v0 || rif.rx_data !== d0) $display("FAIL glitch_outputs: got v=%b d=%h expected v=%b d=%h", rif.rx_valid, rif.rx_data, v0, d0); else pass_cnt++;
    chk_cnt++; if (fe_seen !== fe0 || ov_seen !== ov0) $display("FAIL glitch_pulses: got fe=%0d ov=%0d expected fe=%0d ov=%0d", fe_seen, ov_seen, fe0, ov0); else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    fork
      drive_frame(8'hFF, 1'b1);
      begin
        tick_n(30);
        resetn = 1'b0;
        tick_n(1);
        resetn = 1'b1;
        chk_cnt++; if (rif.rx_data !== 8'h00) $display("FAIL rstmid_data: got %h expected 00", rif.rx_data); else pass_cnt++;
        chk_cnt++; if (rx_busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", rx_busy); else pass_cnt++;
        chk_cnt++; if (rif.rx_valid !== 1'b0 || rif.frame_err !== 1'b0 || rif.overrun !== 1'b0) $display("FAIL rstmid_flags: got v=%b fe=%b ov=%b expected 0 0 0", rif.rx_valid, rif.frame_err, rif.overrun); else pass_cnt++;
      end
    join
    uart_rx = 1'b1;
    tick_n(4);
    chk_cnt++; if (rif.rx_valid !== 1'b0) $display("FAIL rstmid_nodeliver: got %b expected 0", rif.rx_valid); else pass_cnt++;
    drive_frame(8'h81, 1'b1);
    uart_rx = 1'b1;
    tick_n(2);
    chk_cnt++; if (rif.rx_valid !== 1'b1 || rif.rx_data !== 8'h81) $display("FAIL rstmid_next: got v=%b d=%h expected v=1 d=81", rif.rx_valid, rif.rx_data); else pass_cnt++;
    pop();
  endtask

  task automatic test_random();
    logic [7:0] m_data;
    logic m_valid;
    int m_fe, m_ov;
    logic [7:0] b;
    logic ok;
    m_valid = 1'b0; m_data = rif.rx_data;
    m_fe = fe_seen; m_ov = ov_seen;
    for (int f = 0; f < 12; f++) begin
      b = 8'($urandom);
      ok = ($urandom_range(0, 3) != 0);
      drive_frame(b, ok);
      uart_rx = 1'b1;
      tick_n(2 + $urandom_range(0, 6));
      if (!ok) m_fe++;
      else if (!m_valid) begin m_data = b; m_valid = 1'b1; end
      else m_ov++;
      chk_cnt++; if (rif.rx_valid !== m_valid) $display("FAIL rnd%0d_valid: got %b expected %b", f, rif.rx_valid, m_valid); else pass_cnt++;
      chk_cnt++; if (rif.rx_data !== m_data) $display("FAIL rnd%0d_data: got %h expected %h", f, rif.rx_data, m_data); else pass_cnt++;
      chk_cnt++; if (fe_seen !== m_fe || ov_seen !== m_ov) $display("FAIL rnd%0d_pulses: got fe=%0d ov=%0d expected fe=%0d ov=%0d", f, fe_seen, ov_seen, m_fe, m_ov); else pass_cnt++;
      if ($urandom_range(0, 1) == 1) begin
        pop();
        m_valid = 1'b0;
        chk_cnt++; if (rif.rx_valid !== 1'b0) $display("FAIL rnd%0d_pop: got %b expected 0", f, rif.rx_valid); else pass_cnt++;
      end
    end
  endtask

  task automatic test_exclusive_pulses();
    chk_cnt++; if (both_seen !== 0) $display("FAIL pulse_exclusive: got %0d coincident cycles expected 0", both_seen); else pass_cnt++;
  endtask

  initial begin
    rif.rx_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_b2b_pop_on_delivery();
    test_framing();
    test_glitch();
    test_reset_mid_frame();
    test_random();
    test_exclusive_pulses();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
